f2h_dma_req_arbiter: RTL
========================

// Module: f2h_dma_req_arbiter
// PURPOSE
//  Shares one HPS FPGA-to-HPS DMA peripheral request channel (dma_req/dma_single/dma_ack) among
//  NUM_REQ FPGA requesters (e.g. ALSA capture and playback DMA).
//  Round-robin arbitration; the grant is held until the HPS acks or a timeout fires; the ack is routed back to the owner.
//  Sits between the requester conduits and the hps_0_f2h_dma_reqN ports in the top level.
// PARAMETERS
//  NUM_REQ         2     number of requesters (2..8)
//  IDW             1     grant_id width, = max(1, clog2(NUM_REQ))
//  TIMEOUT_CYCLES  4096  max cycles in ISSUE waiting for dma_ack; 0 disables the timeout
// PORTS
//  clk_clk        in   1        system clock; all logic on its rising edge
//  reset_reset_n  in   1        synchronous, active-low reset
//  req_burst      in   NUM_REQ  burst request level, one bit per requester
//  req_single     in   NUM_REQ  single request level, one bit per requester
//  req_ack        out  NUM_REQ  one-cycle ack pulse to the granted requester
//  dma_req        out  1        burst request to HPS
//  dma_single     out  1        single request to HPS
//  dma_ack        in   1        ack from HPS (level, PL330 handshake)
//  grant_id       out  IDW      current or last owner index
//  busy           out  1        1 while state != IDLE
//  timeout_pulse  out  1        one-cycle pulse on timeout
//  timeout_count  out  8        saturating timeout counter
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, all outputs 0, counters 0. Reset mid-operation aborts the handshake at once.
//  All outputs are registered.
//  FSM states: IDLE, ISSUE, RELEASE.
//  IDLE: active[i] = req_burst[i] | req_single[i].
//    Pick the first active index at or after rr pointer, wrapping modulo NUM_REQ.
//    If one is found, the next cycle has: grant_id=winner, state=ISSUE, wait counter=0.
//    Also on that cycle, dma_req=req_burst[winner] and dma_single=req_single[winner], sampled live.
//    Latency: request seen at cycle N -> dma_req high at N+1.
//  ISSUE: dma_req and dma_single follow the owner's live request bits. Wait counter increments each cycle.
//    dma_ack=1 at cycle M: at M+1, req_ack[owner]=1 for one cycle, dma_req=dma_single=0, state=RELEASE.
//    Owner drops both request bits before ack: at the next cycle dma_req=dma_single=0, no req_ack, state=RELEASE.
//    Ack and drop in the same cycle count as an ack.
//    Timeout: wait counter reaches TIMEOUT_CYCLES with no ack.
//      Next cycle: dma_req=dma_single=0, timeout_pulse=1, timeout_count+1 (saturates at 255), state=RELEASE.
//      Ack in the same cycle as the timeout counts as an ack: no timeout pulse.
//  RELEASE: wait for dma_ack==0, then state=IDLE and rr pointer=(owner+1) mod NUM_REQ.
//    The pointer rotates on ack, abort and timeout alike.
//    A requester still asserting is re-arbitrated from IDLE, so there is no back-to-back grant to one owner
//    while others are pending.
//    Minimum turnaround is 1 idle cycle between grants.
//  grant_id holds its value outside ISSUE. Only one req_ack bit is ever set.
//  Requests from non-owners are ignored until IDLE. Arbitration never starves a requester:
//    each active requester is served within NUM_REQ grants.
// TESTING
//  1. req_burst=01 @c0, dma_ack=1 @c5..c6.
//     -> dma_req=1 c1..c5, grant_id=0, req_ack=01 @c6 only, dma_req=0 @c6, IDLE @c8.
//  2. req_burst=11 held, HPS acks 3 cycles after each dma_req rise -> grant_id sequence 0,1,0,1, no gaps beyond 1 idle cycle.
//  3. TIMEOUT_CYCLES=16, req_single=10, no ack.
//     -> dma_single=1 c1..c16, low @c17, timeout_pulse @c17, timeout_count=1, next grant starts from index 0.
//  4. req_burst=01 @c0, dropped @c3, no ack -> dma_req low @c4, req_ack never asserted, busy low @c5.
//  5. reset_reset_n=0 for 1 cycle during ISSUE -> next cycle all outputs 0, state IDLE, rr pointer=0, timeout_count=0.
//  6. 300 forced timeouts -> timeout_count saturates at 255, timeout_pulse still fires on each timeout.

Source files
------------

// File: rtl/f2h_dma_req_arbiter.sv
// Round-robin sharing of one HPS FPGA-to-HPS DMA request channel among NUM_REQ requesters.
// The grant is held until the HPS acks, the owner withdraws or the wait timer expires.
//
// state   | meaning
// IDLE    | no owner; arbitrate among active requesters starting at rr_ptr
// ISSUE   | owner's request bits forwarded to HPS; waiting for dma_ack
// RELEASE | handshake closed; waiting for dma_ack to fall before next arbitration
module f2h_dma_req_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [NUM_REQ-1:0] req_burst,
  input  logic [NUM_REQ-1:0] req_single,
  output logic [NUM_REQ-1:0] req_ack,
  output logic               dma_req,
  output logic               dma_single,
  input  logic               dma_ack,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic               timeout_pulse,
  output logic [7:0]         timeout_count
);

  localparam int WCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [IDW-1:0]     rr_ptr, rr_nxt, gid_nxt;
  logic [WCW-1:0]     wait_cnt, wait_nxt;
  logic               dma_req_nxt, dma_single_nxt, to_pulse_nxt;
  logic [NUM_REQ-1:0] req_ack_nxt;
  logic [7:0]         to_count_nxt;
  logic [NUM_REQ-1:0] active;
  logic               found;
  logic [IDW-1:0]     winner;
  logic               own_burst, own_single, timeout_hit;

  assign active     = req_burst | req_single;
  assign own_burst  = req_burst[grant_id];
  assign own_single = req_single[grant_id];

  // The wait counter equals the number of completed ISSUE cycles, so the limit
  // is reached on the cycle whose increment would make it TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (wait_cnt == WCW'(TIMEOUT_CYCLES - 1));

  always_comb begin : arbitrate
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && active[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_comb begin : next_state
    state_nxt      = state;
    rr_nxt         = rr_ptr;
    gid_nxt        = grant_id;
    wait_nxt       = wait_cnt;
    dma_req_nxt    = 1'b0;
    dma_single_nxt = 1'b0;
    req_ack_nxt    = '0;
    to_pulse_nxt   = 1'b0;
    to_count_nxt   = timeout_count;
    case (state)
      ST_IDLE: begin
        if (found) begin
          state_nxt      = ST_ISSUE;
          gid_nxt        = winner;
          wait_nxt       = '0;
          dma_req_nxt    = req_burst[winner];
          dma_single_nxt = req_single[winner];
        end
      end
      ST_ISSUE: begin
        if (TIMEOUT_CYCLES != 0) wait_nxt = wait_cnt + 1'b1;
        if (dma_ack) begin
          req_ack_nxt[grant_id] = 1'b1;
          state_nxt             = ST_RELEASE;
        end else if (!own_burst && !own_single) begin
          state_nxt = ST_RELEASE;
        end else if (timeout_hit) begin
          to_pulse_nxt = 1'b1;
          if (timeout_count != 8'hFF) to_count_nxt = timeout_count + 8'd1;
          state_nxt = ST_RELEASE;
        end else begin
          dma_req_nxt    = own_burst;
          dma_single_nxt = own_single;
        end
      end
      ST_RELEASE: begin
        if (!dma_ack) begin
          state_nxt = ST_IDLE;
          rr_nxt    = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      wait_cnt      <= '0;
      dma_req       <= 1'b0;
      dma_single    <= 1'b0;
      req_ack       <= '0;
      busy          <= 1'b0;
      timeout_pulse <= 1'b0;
      timeout_count <= 8'd0;
    end else begin
      state         <= state_nxt;
      rr_ptr        <= rr_nxt;
      grant_id      <= gid_nxt;
      wait_cnt      <= wait_nxt;
      dma_req       <= dma_req_nxt;
      dma_single    <= dma_single_nxt;
      req_ack       <= req_ack_nxt;
      busy          <= (state_nxt != ST_IDLE);
      timeout_pulse <= to_pulse_nxt;
      timeout_count <= to_count_nxt;
    end
  end

endmodule
